// File: rtl/kbd_event_unit.sv
// rtl/kbd_event_unit.sv - PS/2 scan byte decoder with event FIFO and press/release counters
// Optional typematic repeat filter: define KBD_REPEAT_FILTER_EN.
module kbd_event_unit #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          code_valid,
  input  logic [7:0]                    code_data,
  input  logic                          evt_ready,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_break,
  output logic                          evt_ext,
  output logic [$clog2(FIFO_DEPTH):0]   evt_level,
  output logic [CNT_W-1:0]              press_count,
  output logic [CNT_W-1:0]              release_count,
  output logic                          overflow,
  output logic                          proto_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t state, state_next;

  logic is_e0, is_f0;
  logic emit, emit_brk, emit_ext, perr_set;
  logic push_req, push, pop, full;

  logic [9:0]       mem [FIFO_DEPTH];
  logic [LVL_W-1:0] wr_ptr, rd_ptr;
  logic [9:0]       head;

  assign is_e0 = (code_data == 8'hE0);
  assign is_f0 = (code_data == 8'hF0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_brk   = 1'b0;
    emit_ext   = 1'b0;
    perr_set   = 1'b0;
    if (code_valid) begin
      case (state)
        IDLE: begin
          if (is_e0)      state_next = EXT;
          else if (is_f0) state_next = BRK;
          else            emit       = 1'b1;
        end
        EXT: begin
          if (is_f0)      state_next = EXT_BRK;
          else if (is_e0) state_next = EXT;
          else begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            state_next = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          state_next = IDLE;
          if (is_e0 || is_f0) begin
            perr_set = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = (state == EXT_BRK);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef KBD_REPEAT_FILTER_EN
  logic       held_valid;
  logic [7:0] held_code;
  logic       held_ext;
  logic       held_match;

  assign held_match = held_valid && (held_code == code_data) && (held_ext == emit_ext);
  // A press of the key already held down is typematic repeat and is swallowed.
  assign push_req   = emit && !(!emit_brk && held_match);

  always_ff @(posedge clock) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_code  <= 8'h00;
      held_ext   <= 1'b0;
    end else if (emit) begin
      if (!emit_brk) begin
        held_valid <= 1'b1;
        held_code  <= code_data;
        held_ext   <= emit_ext;
      end else if (held_match) begin
        held_valid <= 1'b0;
      end
    end
  end
`else
  assign push_req = emit;
`endif

  assign evt_level = wr_ptr - rd_ptr;
  assign evt_valid = (evt_level != '0);
  assign full      = (evt_level == LVL_W'(FIFO_DEPTH));
  assign pop       = evt_valid && evt_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push      = push_req && (!full || pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {emit_ext, emit_brk, code_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      press_count   <= '0;
      release_count <= '0;
      overflow      <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LVL_W'(1);
      if (pop)  rd_ptr <= rd_ptr + LVL_W'(1);
      if (push_req && !emit_brk) press_count   <= press_count + CNT_W'(1);
      if (push_req && emit_brk)  release_count <= release_count + CNT_W'(1);
      if (push_req && !push)     overflow      <= 1'b1;
      if (perr_set)              proto_err     <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign evt_code  = evt_valid ? head[7:0] : 8'h00;
  assign evt_break = evt_valid ? head[8]   : 1'b0;
  assign evt_ext   = evt_valid ? head[9]   : 1'b0;

endmodule
